// File: rtl/uart_display_sched.sv
// Byte display scheduler: buffers received UART bytes in a small FIFO and shows each one
// on a two-digit hex display for HOLD_CYCLES, with GAP_CYCLES of blanking between bytes.
module uart_display_sched #(
   parameter int unsigned HOLD_CYCLES = 25000000,
   parameter int unsigned GAP_CYCLES  = 2500000,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_rx_dv,
   input  logic [7:0]                    i_rx_byte,
   output logic [7:0]                    o_value,
   output logic                          o_blank,
   output logic                          o_busy,
   output logic                          o_drop,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [AW:0]   FULL_LVL = FIFO_DEPTH[AW:0];

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      GAP
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [7:0]      val_q;
   logic            blank_q;
   logic [7:0]      out_val_q;
   logic            out_blank_q;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_q, wr_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [AW:0]     level_q, level_d;
   logic            drop_q, drop_d;
   logic            push;
   logic            pop;
   logic [7:0]      head;

   // Pop decision depends only on registered state, so push may use it without a loop.
   always_comb begin
      pop = 1'b0;
      unique case (state_q)
         IDLE:    pop = (level_q != '0);
         SHOW:    pop = (cnt_q == '0) && (level_q != '0) && (GAP_CYCLES == 0);
         GAP:     pop = (cnt_q == '0) && (level_q != '0);
         default: pop = 1'b0;
      endcase
   end

   always_comb begin
      head    = mem_q[rd_q];
      push    = i_rx_dv && ((level_q != FULL_LVL) || pop);
      drop_d  = i_rx_dv && (level_q == FULL_LVL) && !pop;
      wr_d    = push ? wr_q + 1'b1 : wr_q;
      rd_d    = pop  ? rd_q + 1'b1 : rd_q;
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_q] <= i_rx_byte;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
         drop_q  <= drop_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         val_q   <= '0;
         blank_q <= 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pop) begin
                  val_q   <= head;
                  blank_q <= 1'b0;
                  cnt_q   <= HOLD_LD;
                  state_q <= SHOW;
               end
            end
            SHOW: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (pop) begin
                  val_q <= head;
                  cnt_q <= HOLD_LD;
               end else if (level_q != '0) begin
                  blank_q <= 1'b1;
                  cnt_q   <= GAP_LD;
                  state_q <= GAP;
               end else begin
                  state_q <= IDLE;
               end
            end
            GAP: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (pop) begin
                  val_q   <= head;
                  blank_q <= 1'b0;
                  cnt_q   <= HOLD_LD;
                  state_q <= SHOW;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Display register stage: a byte reaches the digits one edge after its pop,
   // shifting every SHOW/GAP window equally so durations are unchanged.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         out_val_q   <= '0;
         out_blank_q <= 1'b1;
      end else begin
         out_val_q   <= val_q;
         out_blank_q <= blank_q;
      end
   end

   assign o_value = out_val_q;
   assign o_blank = out_blank_q;
   assign o_busy  = (state_q != IDLE) || (level_q != '0);
   assign o_drop  = drop_q;
   assign o_level = level_q;

endmodule

// File: tb/tb_uart_display_sched.sv
// Directed bench for uart_display_sched: a scoreboard queue of bytes expected on the display,
// popped by a monitor that also checks hold and gap lengths.
module tb_uart_display_sched;

   localparam int unsigned HOLD = 8;
   localparam int unsigned GAPC = 2;
   localparam int unsigned DEPTH = 4;

   logic       clk;
   logic       rst_n;
   logic       rx_dv;
   logic [7:0] rx_byte;
   logic [7:0] value;
   logic       blank;
   logic       busy;
   logic       drop;
   logic [2:0] level;

   int n_assert = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   uart_display_sched #(
      .HOLD_CYCLES(HOLD),
      .GAP_CYCLES (GAPC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_rx_dv  (rx_dv),
      .i_rx_byte(rx_byte),
      .o_value  (value),
      .o_blank  (blank),
      .o_busy   (busy),
      .o_drop   (drop),
      .o_level  (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_value"}, 32'(value), 32'h00);
      chk({tag, "_blank"}, 32'(blank), 32'h1);
      chk({tag, "_busy"},  32'(busy),  32'h0);
      chk({tag, "_level"}, 32'(level), 32'h0);
      chk({tag, "_drop"},  32'(drop),  32'h0);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (k < budget && (busy || exp_q.size() != 0)) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_idle_in_time"}, 32'(k < budget), 32'h1);
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
   endtask

   // Display monitor
   logic       prev_blank = 1'b1;
   logic [7:0] prev_val   = 8'h00;
   int         run        = 0;
   logic       after_show = 1'b0;
   logic [7:0] want;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_blank = 1'b1;
         prev_val   = 8'h00;
         run        = 0;
         after_show = 1'b0;
      end else begin
         if (!blank) begin
            if (prev_blank || value != prev_val) begin
               if (prev_blank && after_show) chk("gap_len", 32'(run), 32'(GAPC));
               chk("display_expected", 32'(exp_q.size() != 0), 32'h1);
               if (exp_q.size() != 0) begin
                  want = exp_q.pop_front();
                  chk("display_order", 32'(value), 32'(want));
               end
               run = 1;
               after_show = 1'b0;
            end else begin
               run++;
            end
         end else begin
            if (!prev_blank) begin
               chk("show_len", 32'(run), 32'(HOLD));
               after_show = 1'b1;
               run = 1;
            end else begin
               run++;
            end
         end
         prev_blank = blank;
         prev_val   = value;
      end
   end

   initial begin
      rst_n   = 1'b0;
      rx_dv   = 1'b0;
      rx_byte = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset_outputs("in_reset");
      rst_n = 1'b1;

      // Idle after reset release
      repeat (20) @(negedge clk);
      chk_reset_outputs("idle20");
      repeat (20) @(negedge clk);
      chk_reset_outputs("idle40");

      // Single byte: latency, hold length, idle hold
      @(negedge clk);
      rx_dv = 1'b1; rx_byte = 8'h42; exp_q.push_back(8'h42);
      @(negedge clk); rx_dv = 1'b0;
      chk("single_n1_level", 32'(level), 32'h1);
      chk("single_n1_busy",  32'(busy),  32'h1);
      @(negedge clk);
      chk("single_n2_blank", 32'(blank), 32'h1);
      chk("single_n2_level", 32'(level), 32'h0);
      @(negedge clk);
      chk("single_n3_value", 32'(value), 32'h42);
      chk("single_n3_blank", 32'(blank), 32'h0);
      repeat (6) @(negedge clk);
      chk("single_n9_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("single_n10_busy", 32'(busy), 32'h0);
      repeat (10) @(negedge clk);
      chk("single_hold_value", 32'(value), 32'h42);
      chk("single_hold_blank", 32'(blank), 32'h0);
      chk("single_hold_busy",  32'(busy),  32'h0);

      // Two bytes back-to-back with blanking gap
      @(negedge clk);
      rx_dv = 1'b1; rx_byte = 8'h12; exp_q.push_back(8'h12);
      @(negedge clk);
      rx_byte = 8'h34; exp_q.push_back(8'h34);
      @(negedge clk); rx_dv = 1'b0;
      repeat (8) @(negedge clk);
      chk("pair_n10_value", 32'(value), 32'h12);
      @(negedge clk);
      chk("pair_n11_blank", 32'(blank), 32'h1);
      repeat (2) @(negedge clk);
      chk("pair_n13_value", 32'(value), 32'h34);
      chk("pair_n13_blank", 32'(blank), 32'h0);
      repeat (6) @(negedge clk);
      chk("pair_n19_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("pair_n20_busy", 32'(busy), 32'h0);

      // Six pushes: one popped, four buffered, last dropped
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 5) begin
            chk("burst_full_level", 32'(level), 32'h4);
            chk("burst_drop_pre",   32'(drop),  32'h0);
         end
         rx_dv = 1'b1;
         rx_byte = 8'(8'hA0 + i);
         if (i < 5) exp_q.push_back(8'(8'hA0 + i));
      end
      @(negedge clk); rx_dv = 1'b0;
      chk("burst_drop_pulse", 32'(drop),  32'h1);
      chk("burst_drop_level", 32'(level), 32'h4);
      @(negedge clk);
      chk("burst_drop_end", 32'(drop), 32'h0);
      wait_idle(200, "burst");

      // Full FIFO, push coincident with GAP-end pop
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         rx_dv = 1'b1;
         rx_byte = 8'(8'hB0 + i);
         exp_q.push_back(8'(8'hB0 + i));
      end
      @(negedge clk); rx_dv = 1'b0;
      repeat (6) @(negedge clk);
      chk("gapend_pre_level", 32'(level), 32'h4);
      rx_dv = 1'b1; rx_byte = 8'hB5; exp_q.push_back(8'hB5);
      @(negedge clk); rx_dv = 1'b0;
      chk("gapend_level", 32'(level), 32'h4);
      chk("gapend_drop",  32'(drop),  32'h0);
      wait_idle(200, "gapend");

      // Reset mid-SHOW with three bytes buffered
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rx_dv = 1'b1;
         rx_byte = 8'(8'hC0 + i);
         exp_q.push_back(8'(8'hC0 + i));
      end
      @(negedge clk); rx_dv = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pre_level", 32'(level), 32'h3);
      chk("rst_pre_value", 32'(value), 32'hC0);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("rst_now");
      exp_q.delete();
      @(negedge clk);
      rx_dv = 1'b1; rx_byte = 8'hDD;
      @(negedge clk); rx_dv = 1'b0;
      chk_reset_outputs("rst_held");
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk_reset_outputs("rst_after");

      // Fresh push after reset is displayed with normal latency
      rx_dv = 1'b1; rx_byte = 8'hE7; exp_q.push_back(8'hE7);
      @(negedge clk); rx_dv = 1'b0;
      chk("post_rst_level", 32'(level), 32'h1);
      repeat (2) @(negedge clk);
      chk("post_rst_value", 32'(value), 32'hE7);
      wait_idle(200, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_display_sched.md
UART_DISPLAY_SCHED -- requirements
Module: uart_display_sched

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 25000000; cycles each byte stays displayed, legal range >= 1.
REQ-002 SHALL have parameter GAP_CYCLES, default 2500000; blanking cycles between consecutive bytes; 0 means no gap.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4; byte buffer entries; power of two, >= 2.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port i_clk, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_rx_dv, input, 1, one-cycle strobe marking i_rx_byte valid.
REQ-008 SHALL have port i_rx_byte, input, 8, received byte; sampled only when i_rx_dv=1.
REQ-009 SHALL have port o_value, output, 8, byte for the two hex digits (upper nibble to digit 1, lower nibble to digit 2).
REQ-010 SHALL have port o_blank, output, 1, 1 = both digits dark.
REQ-011 SHALL have port o_busy, output, 1, 1 when FSM not IDLE or FIFO non-empty.
REQ-012 SHALL have port o_drop, output, 1, one-cycle pulse when a byte is discarded.
REQ-013 SHALL have port o_level, output, clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-014 SHALL push i_rx_byte into the FIFO on each edge with i_rx_dv=1 unless FIFO full and no pop in the same cycle.
REQ-015 SHALL, on a push attempt to a full FIFO without a same-cycle pop, discard the byte, keep contents unchanged, and assert o_drop for exactly the next cycle.
REQ-016 SHALL accept a push when full if a pop occurs in the same cycle; o_level unchanged, no o_drop.
REQ-017 SHALL pop in FIFO order; read/write pointers wrap modulo FIFO_DEPTH; o_level never exceeds FIFO_DEPTH nor underflows.
REQ-018 SHALL implement FSM states IDLE, SHOW, GAP with a down-counter wide enough for max(HOLD_CYCLES, GAP_CYCLES).
REQ-019 SHALL, in IDLE with o_level>0, pop the head byte, load o_value, clear o_blank, load counter HOLD_CYCLES-1, enter SHOW.
REQ-020 SHALL, in SHOW, decrement the counter each cycle; at counter 0: if o_level>0 and GAP_CYCLES>0, set o_blank, load GAP_CYCLES-1, enter GAP; if o_level>0 and GAP_CYCLES=0, pop/load directly and stay in SHOW with counter HOLD_CYCLES-1; else enter IDLE.
REQ-021 SHALL, in GAP, decrement; at counter 0 pop the head byte, load o_value, clear o_blank, load HOLD_CYCLES-1, enter SHOW.
REQ-022 SHALL, entering IDLE from SHOW, keep the last o_value displayed with o_blank=0.
REQ-023 SHALL give latency: byte pushed into empty FIFO with FSM in IDLE appears on o_value at the 2nd rising edge after the edge sampling i_rx_dv.
REQ-024 SHALL display each popped byte for exactly HOLD_CYCLES cycles and blank exactly GAP_CYCLES cycles between back-to-back bytes.
REQ-025 SHALL accept pushes in every FSM state, including the pop cycle.

Reset
REQ-026 SHALL, while i_rst_n=0, force: FSM IDLE, FIFO empty, o_level=0, o_value=8'h00, o_blank=1, o_busy=0, o_drop=0, counter=0.
REQ-027 SHALL, on reset asserted mid-SHOW or mid-GAP, abandon the current byte and flush all buffered bytes; no byte is displayed after release until a new push.
REQ-028 SHALL ignore i_rx_dv in the first edge where i_rst_n is sampled 0; operation resumes on the first edge after deassertion.

Verification (HOLD_CYCLES=8, GAP_CYCLES=2, FIFO_DEPTH=4)
REQ-029 SHALL check: reset release, no input -> o_value=8'h00, o_blank=1, o_busy=0, o_level=0 indefinitely.
REQ-030 SHALL check: single push 8'h42 at edge N -> o_value=8'h42, o_blank=0 from edge N+2; SHOW lasts 8 cycles; then IDLE holding 8'h42, o_busy=0.
REQ-031 SHALL check: pushes 8'h12, 8'h34 back-to-back -> 8'h12 for 8 cycles, o_blank=1 for 2 cycles, 8'h34 for 8 cycles, then IDLE.
REQ-032 SHALL check: 6 consecutive pushes 8'hA0..8'hA5 from IDLE -> A0 popped at first opportunity, A1..A4 buffered, A5 dropped with one-cycle o_drop; displayed order A0,A1,A2,A3,A4.
REQ-033 SHALL check: FIFO full and push coincident with GAP-end pop -> byte accepted, o_level stays 4, o_drop=0.
REQ-034 SHALL check: i_rst_n pulsed low during SHOW with 3 bytes buffered -> outputs return to reset values immediately; nothing further displayed after release.
